// File: rtl/pomo_pkg.sv
// Shared types and elaboration-time helpers for the Pomodoro sequencer.
// Durations become BCD constants here, so the datapath never converts binary to BCD.
package pomo_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StPause   = 2'd2,
        StExpired = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PhWork  = 2'd0,
        PhShort = 2'd1,
        PhLong  = 2'd2
    } phase_e;

    function automatic logic [7:0] to_bcd8(input int unsigned v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Index 3 is the unused phase code; it maps to 00 minutes.
    function automatic logic [3:0][7:0] dur_lut(input int unsigned work_min,
                                                input int unsigned short_min,
                                                input int unsigned long_min);
        return {8'h00, to_bcd8(long_min), to_bcd8(short_min), to_bcd8(work_min)};
    endfunction

    function automatic logic [7:0] bcd8_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// Two-digit BCD mm:ss down counter with a parallel load of mm:00.
module bcd_mmss_down
    import pomo_pkg::*;
#(
    parameter logic [7:0] RST_MIN = 8'h25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic       dec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       zero_next
);

    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;

    always_comb begin
        w_min_nxt = r_min;
        w_sec_nxt = r_sec;
        if (load) begin
            w_min_nxt = load_min;
            w_sec_nxt = 8'h00;
        end else if (dec) begin
            if (r_sec == 8'h00) begin
                w_sec_nxt = 8'h59;
                w_min_nxt = bcd8_dec(r_min);
            end else begin
                w_sec_nxt = bcd8_dec(r_sec);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= RST_MIN;
            r_sec <= 8'h00;
        end else begin
            r_min <= w_min_nxt;
            r_sec <= w_sec_nxt;
        end
    end

    assign min_bcd   = r_min;
    assign sec_bcd   = r_sec;
    assign zero_next = (r_min == 8'h00) && (r_sec == 8'h01);

endmodule

// File: rtl/pomo_sequencer.sv
// Pomodoro work/short/long break sequencer: 1 s prescaler, BCD countdown, pause,
// expiry alarm and display blink request.
module pomo_sequencer
    import pomo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned WORK_MIN   = 25,
    parameter int unsigned SHORT_MIN  = 5,
    parameter int unsigned LONG_MIN   = 15,
    parameter int unsigned LONG_EVERY = 4,
    parameter int unsigned BLINK_HZ   = 2,
    parameter int unsigned ALARM_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lever,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       blink_7sd,
    output logic [1:0] phase,
    output logic       running,
    output logic       alarm,
    output logic [3:0] done_cnt
);

    localparam int unsigned PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
    localparam int unsigned BLINK_P  = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int unsigned BW       = (BLINK_P > 1) ? $clog2(BLINK_P) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_P - 1);
    localparam logic [3:0][7:0] DUR_LUT = dur_lut(WORK_MIN, SHORT_MIN, LONG_MIN);
    localparam logic [3:0] LONG_N   = 4'(LONG_EVERY);
    localparam logic [7:0] ALARM_N  = 8'(ALARM_SEC);

    state_e        r_state, w_state_nxt;
    phase_e        r_phase, w_phase_nxt;
    logic [3:0]    r_done, w_done_nxt;
    logic [PW-1:0] r_pre, w_pre_nxt;
    logic [BW-1:0] r_div, w_div_nxt;
    logic          r_blink, w_blink_nxt;
    logic          r_alarm, w_alarm_nxt;
    logic [7:0]    r_acnt, w_acnt_nxt;

    logic          w_tc;
    logic          w_load;
    logic          w_dec;
    logic          w_zero_next;
    logic [7:0]    w_load_min;
    logic          w_div_wrap;
    logic [BW-1:0] w_div_run;
    logic          w_blink_run;
    logic [PW-1:0] w_pre_run;

    assign w_tc        = (r_pre == PRE_TC);
    assign w_pre_run   = w_tc ? '0 : r_pre + PW'(1);
    assign w_div_wrap  = (r_div == BLINK_TC);
    assign w_div_run   = w_div_wrap ? '0 : r_div + BW'(1);
    assign w_blink_run = r_blink ^ w_div_wrap;
    assign w_load_min  = DUR_LUT[w_phase_nxt];

    // Blink divider defaults to cleared so IDLE and RUN always hold it at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_done_nxt  = r_done;
        w_pre_nxt   = r_pre;
        w_div_nxt   = '0;
        w_blink_nxt = 1'b0;
        w_alarm_nxt = r_alarm;
        w_acnt_nxt  = r_acnt;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (lever) begin
                    w_state_nxt = StRun;
                    w_pre_nxt   = '0;
                end
            end
            StRun: begin
                // An expiring tick beats a simultaneous lever; otherwise the lever wins.
                if (w_tc && w_zero_next) begin
                    w_state_nxt = StExpired;
                    w_dec       = 1'b1;
                    w_pre_nxt   = '0;
                    w_alarm_nxt = (ALARM_N != 8'd0);
                    w_acnt_nxt  = 8'd0;
                    if (r_phase == PhWork) begin
                        w_done_nxt = r_done + 4'd1;
                    end
                end else if (lever) begin
                    w_state_nxt = StPause;
                end else begin
                    w_dec     = w_tc;
                    w_pre_nxt = w_pre_run;
                end
            end
            StPause: begin
                if (lever) begin
                    w_state_nxt = StRun;
                end else begin
                    w_div_nxt   = w_div_run;
                    w_blink_nxt = w_blink_run;
                end
            end
            StExpired: begin
                if (lever) begin
                    w_state_nxt = StIdle;
                    w_alarm_nxt = 1'b0;
                    w_pre_nxt   = '0;
                    w_load      = 1'b1;
                    if (r_phase == PhWork && r_done == LONG_N) begin
                        w_phase_nxt = PhLong;
                        w_done_nxt  = 4'd0;
                    end else if (r_phase == PhWork) begin
                        w_phase_nxt = PhShort;
                    end else begin
                        w_phase_nxt = PhWork;
                    end
                end else begin
                    w_pre_nxt   = w_pre_run;
                    w_div_nxt   = w_div_run;
                    w_blink_nxt = w_blink_run;
                    if (r_alarm && w_tc) begin
                        w_acnt_nxt = r_acnt + 8'd1;
                        if (r_acnt + 8'd1 == ALARM_N) begin
                            w_alarm_nxt = 1'b0;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_phase <= PhWork;
            r_done  <= 4'd0;
            r_pre   <= '0;
            r_div   <= '0;
            r_blink <= 1'b0;
            r_alarm <= 1'b0;
            r_acnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_done  <= w_done_nxt;
            r_pre   <= w_pre_nxt;
            r_div   <= w_div_nxt;
            r_blink <= w_blink_nxt;
            r_alarm <= w_alarm_nxt;
            r_acnt  <= w_acnt_nxt;
        end
    end

    bcd_mmss_down #(
        .RST_MIN(DUR_LUT[PhWork])
    ) u_mmss (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_min (w_load_min),
        .dec      (w_dec),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .zero_next(w_zero_next)
    );

    assign blink_7sd = r_blink;
    assign phase     = r_phase;
    assign running   = (r_state == StRun);
    assign alarm     = r_alarm;
    assign done_cnt  = r_done;

endmodule

// File: tb/tb_pomo_sequencer.sv
// Directed bench for pomo_sequencer with a 4-cycle second; expected values hand-computed.
module tb_pomo_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lever = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       blink_7sd;
    logic [1:0] phase;
    logic       running;
    logic       alarm;
    logic [3:0] done_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pomo_sequencer #(
        .CLK_HZ    (4),
        .WORK_MIN  (1),
        .SHORT_MIN (1),
        .LONG_MIN  (2),
        .LONG_EVERY(2),
        .BLINK_HZ  (1),
        .ALARM_SEC (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lever    (lever),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .blink_7sd(blink_7sd),
        .phase    (phase),
        .running  (running),
        .alarm    (alarm),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    // Snapshot layout: {min, sec, phase, running, blink, alarm, done_cnt}.
    function automatic logic [24:0] mk(input logic [7:0] m, input logic [7:0] s,
                                       input logic [1:0] ph, input logic run,
                                       input logic bl, input logic al, input logic [3:0] dn);
        return {m, s, ph, run, bl, al, dn};
    endfunction

    function automatic logic [24:0] snap();
        return {min_bcd, sec_bcd, phase, running, blink_7sd, alarm, done_cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse();
        lever = 1'b1;
        @(negedge clk);
        lever = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check("reset_async", 32'(snap()), 32'(mk(8'h01, 8'h00, 0, 0, 0, 0, 0)));
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            check("idle_hold", 32'(snap()), 32'(mk(8'h01, 8'h00, 0, 0, 0, 0, 0)));
        end

        // First WORK phase, with a pause at 00:45.
        pulse();
        check("start_run", 32'(snap()), 32'(mk(8'h01, 8'h00, 0, 1, 0, 0, 0)));
        cyc(3);
        check("pre_first_tick", 32'({min_bcd, sec_bcd}), 32'h0100);
        cyc(1);
        check("first_tick", 32'({min_bcd, sec_bcd}), 32'h0059);
        cyc(56);
        check("at_0045", 32'({min_bcd, sec_bcd}), 32'h0045);
        cyc(2);
        pulse();
        check("paused", 32'(snap()), 32'(mk(8'h00, 8'h45, 0, 0, 0, 0, 0)));
        cyc(2);
        check("pause_blink_on", 32'(blink_7sd), 32'd1);
        cyc(2);
        check("pause_blink_off", 32'(blink_7sd), 32'd0);
        cyc(16);
        check("pause_hold", 32'({min_bcd, sec_bcd, running}), 32'({16'h0045, 1'b0}));
        pulse();
        check("resumed", 32'({min_bcd, sec_bcd, running, blink_7sd}), 32'({16'h0045, 2'b10}));
        cyc(1);
        check("resume_no_tick", 32'({min_bcd, sec_bcd}), 32'h0045);
        cyc(1);
        check("resume_tick", 32'({min_bcd, sec_bcd}), 32'h0044);
        cyc(136);
        check("at_0010", 32'({min_bcd, sec_bcd}), 32'h0010);
        cyc(4);
        check("at_0009", 32'({min_bcd, sec_bcd}), 32'h0009);
        cyc(32);
        check("at_0001", 32'({min_bcd, sec_bcd, running}), 32'({16'h0001, 1'b1}));
        cyc(4);
        check("expired_work1", 32'(snap()), 32'(mk(8'h00, 8'h00, 0, 0, 0, 1, 1)));
        cyc(2);
        check("exp_blink_on", 32'(blink_7sd), 32'd1);
        cyc(2);
        check("exp_blink_off", 32'(blink_7sd), 32'd0);
        cyc(3);
        check("alarm_last", 32'(alarm), 32'd1);
        cyc(1);
        check("alarm_off", 32'(alarm), 32'd0);
        pulse();
        check("ack_to_short", 32'(snap()), 32'(mk(8'h01, 8'h00, 1, 0, 0, 0, 1)));

        // SHORT phase: lever on the expiring tick is ignored.
        pulse();
        check("short_run", 32'(running), 32'd1);
        cyc(236);
        check("short_0001", 32'({min_bcd, sec_bcd}), 32'h0001);
        cyc(3);
        pulse();
        check("expiry_beats_lever", 32'(snap()), 32'(mk(8'h00, 8'h00, 1, 0, 0, 1, 1)));
        cyc(3);
        pulse();
        check("ack_to_work", 32'(snap()), 32'(mk(8'h01, 8'h00, 0, 0, 0, 0, 1)));

        // Second WORK phase: lever on a non-expiring tick pauses and drops the tick.
        pulse();
        cyc(4);
        check("w2_0059", 32'({min_bcd, sec_bcd}), 32'h0059);
        cyc(3);
        pulse();
        check("lever_beats_tick", 32'(snap()), 32'(mk(8'h00, 8'h59, 0, 0, 0, 0, 1)));
        cyc(2);
        pulse();
        check("w2_resumed", 32'({min_bcd, sec_bcd, running}), 32'({16'h0059, 1'b1}));
        cyc(1);
        check("w2_frozen_pre", 32'({min_bcd, sec_bcd}), 32'h0058);
        cyc(231);
        check("w2_0001", 32'({min_bcd, sec_bcd}), 32'h0001);
        cyc(1);
        check("expired_work2", 32'(snap()), 32'(mk(8'h00, 8'h00, 0, 0, 0, 1, 2)));
        pulse();
        check("ack_to_long", 32'(snap()), 32'(mk(8'h02, 8'h00, 2, 0, 0, 0, 0)));

        // LONG phase, then asynchronous reset while the alarm is high.
        pulse();
        cyc(4);
        check("long_0159", 32'({min_bcd, sec_bcd}), 32'h0159);
        cyc(476);
        check("expired_long", 32'(snap()), 32'(mk(8'h00, 8'h00, 2, 0, 0, 1, 0)));
        cyc(2);
        check("pre_reset_state", 32'({blink_7sd, alarm}), 32'b11);
        rst = 1'b1;
        #1 check("reset_mid", 32'(snap()), 32'(mk(8'h01, 8'h00, 0, 0, 0, 0, 0)));
        cyc(1);
        rst = 1'b0;
        cyc(2);
        check("post_reset_idle", 32'(snap()), 32'(mk(8'h01, 8'h00, 0, 0, 0, 0, 0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
